// File: rtl/uart_tx_scheduler.sv
// Sequencer in front of the UART transmitter: round-robin arbitration between a
// 1-byte register-read source and a 2-byte (LSB first) ALU source, one byte per frame.
module uart_tx_scheduler #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REG_VALID,
  input  logic [7:0]  REG_DATA,
  input  logic        ALU_VALID,
  input  logic [15:0] ALU_DATA,
  output logic        REG_ACK,
  output logic        ALU_ACK,
  input  logic        TX_BUSY,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_DATA_VALID,
  output logic        SCHED_BUSY,
  output logic        MSG_DONE,
  output logic        MSG_SRC
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       last_grant;     // 1 = ALU won the previous arbitration
  logic       two_byte;       // message in flight came from the ALU
  logic       byte_sel;       // 0 = sending byte 0, 1 = sending byte 1
  logic       issue_after_gap;
  logic [3:0] gap_cnt;
  logic [7:0] msg_hi;

  logic start;
  logic grant_alu;
  logic bytes_left;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_next = state;
    start      = (state == IDLE) && !TX_BUSY && (REG_VALID || ALU_VALID);
    grant_alu  = ALU_VALID && (!REG_VALID || !last_grant);
    bytes_left = two_byte && !byte_sel;

    case (state)
      IDLE:      if (start) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (TX_BUSY) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (HAS_GAP)         state_next = GAP;
          else if (bytes_left) state_next = ISSUE;
          else                 state_next = IDLE;
        end
      end
      GAP:       if (gap_cnt == 4'd0) state_next = issue_after_gap ? ISSUE : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      two_byte        <= 1'b0;
      byte_sel        <= 1'b0;
      issue_after_gap <= 1'b0;
      gap_cnt         <= 4'd0;
      TX_P_DATA       <= 8'h00;
      TX_DATA_VALID   <= 1'b0;
      REG_ACK         <= 1'b0;
      ALU_ACK         <= 1'b0;
      SCHED_BUSY      <= 1'b0;
      MSG_DONE        <= 1'b0;
      MSG_SRC         <= 1'b0;
    end else begin
      state         <= state_next;
      SCHED_BUSY    <= (state_next != IDLE);
      TX_DATA_VALID <= (state_next == ISSUE);
      REG_ACK       <= 1'b0;
      ALU_ACK       <= 1'b0;
      MSG_DONE      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            REG_ACK    <= !grant_alu;
            ALU_ACK    <= grant_alu;
            MSG_SRC    <= grant_alu;
            last_grant <= grant_alu;
            two_byte   <= grant_alu;
            byte_sel   <= 1'b0;
            TX_P_DATA  <= grant_alu ? ALU_DATA[7:0] : REG_DATA;
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            issue_after_gap <= bytes_left;
            gap_cnt         <= GAP_LAST;
            if (bytes_left) begin
              byte_sel <= 1'b1;
              if (!HAS_GAP) TX_P_DATA <= msg_hi;
            end else begin
              MSG_DONE <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt != 4'd0)      gap_cnt   <= gap_cnt - 4'd1;
          else if (issue_after_gap) TX_P_DATA <= msg_hi;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the data buffer is not reset; it is always written at capture before it is read.
  always_ff @(posedge CLK) begin
    if (start) msg_hi <= ALU_DATA[15:8];
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: scoreboard of expected ACK sources, frame
// bytes and MSG_DONE sources, plus a second instance with a 3-cycle inter-frame gap.
module tb_uart_tx_scheduler;

  logic        CLK;
  logic        RST;
  logic        REG_VALID;
  logic [7:0]  REG_DATA;
  logic        ALU_VALID;
  logic [15:0] ALU_DATA;
  logic        REG_ACK;
  logic        ALU_ACK;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID;
  logic        SCHED_BUSY;
  logic        MSG_DONE;
  logic        MSG_SRC;

  logic        g_reg_valid;
  logic [7:0]  g_reg_data;
  logic        g_alu_valid;
  logic [15:0] g_alu_data;
  logic        g_reg_ack;
  logic        g_alu_ack;
  logic        g_tx_busy;
  logic [7:0]  g_tx_p_data;
  logic        g_tx_data_valid;
  logic        g_sched_busy;
  logic        g_msg_done;
  logic        g_msg_src;

  uart_tx_scheduler #(.GAP_CYCLES(0)) dut (
    .CLK(CLK), .RST(RST),
    .REG_VALID(REG_VALID), .REG_DATA(REG_DATA),
    .ALU_VALID(ALU_VALID), .ALU_DATA(ALU_DATA),
    .REG_ACK(REG_ACK), .ALU_ACK(ALU_ACK),
    .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .SCHED_BUSY(SCHED_BUSY), .MSG_DONE(MSG_DONE), .MSG_SRC(MSG_SRC)
  );

  uart_tx_scheduler #(.GAP_CYCLES(3)) dut_gap (
    .CLK(CLK), .RST(RST),
    .REG_VALID(g_reg_valid), .REG_DATA(g_reg_data),
    .ALU_VALID(g_alu_valid), .ALU_DATA(g_alu_data),
    .REG_ACK(g_reg_ack), .ALU_ACK(g_alu_ack),
    .TX_BUSY(g_tx_busy), .TX_P_DATA(g_tx_p_data), .TX_DATA_VALID(g_tx_data_valid),
    .SCHED_BUSY(g_sched_busy), .MSG_DONE(g_msg_done), .MSG_SRC(g_msg_src)
  );

  localparam int FRAME_CYCLES = 6;

  int checks = 0;
  int errors = 0;

  bit         exp_ack[$];    // 0 = REG, 1 = ALU
  logic [7:0] exp_byte[$];
  bit         exp_done[$];

  int         ack_cnt = 0;
  int         done_cnt = 0;
  int         issue_cnt = 0;
  int         cyc = 0;
  int         last_done_cyc = -1;
  bit         spacing_on = 0;
  logic [7:0] cur_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transmitter model: Busy rises two cycles after the start strobe and lasts a frame.
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (TX_DATA_VALID && !RST) begin
        repeat (2) begin @(posedge CLK); #1; end
        TX_BUSY = 1'b1;
        repeat (FRAME_CYCLES) begin @(posedge CLK); #1; end
        TX_BUSY = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT produces an ACK, a frame start or MSG_DONE.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (RST) begin
      cur_byte = 8'h00;
    end else begin
      if (REG_ACK || ALU_ACK) begin
        ack_cnt++;
        check("ack_exclusive", {31'd0, REG_ACK & ALU_ACK}, 32'd0);
        if (exp_ack.size() == 0) check("ack_unexpected", exp_ack.size(), 1);
        else                     check("ack_src", {31'd0, ALU_ACK}, {31'd0, exp_ack.pop_front()});
        if (spacing_on && last_done_cyc >= 0) check("ack_spacing", cyc - last_done_cyc, 1);
      end
      if (TX_DATA_VALID) begin
        issue_cnt++;
        check("issue_while_busy", {31'd0, TX_BUSY}, 32'd0);
        if (exp_byte.size() == 0) check("issue_unexpected", exp_byte.size(), 1);
        else                      check("tx_byte", {24'd0, TX_P_DATA}, {24'd0, exp_byte.pop_front()});
        cur_byte = TX_P_DATA;
      end
      if (MSG_DONE) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_done.size() == 0) check("done_unexpected", exp_done.size(), 1);
        else                      check("msg_src", {31'd0, MSG_SRC}, {31'd0, exp_done.pop_front()});
      end
      if (TX_BUSY) check("p_data_stable", {24'd0, TX_P_DATA}, {24'd0, cur_byte});
    end
  end

  task automatic push_reg(input logic [7:0] d);
    exp_ack.push_back(1'b0);
    exp_byte.push_back(d);
    exp_done.push_back(1'b0);
  endtask

  task automatic push_alu(input logic [15:0] d);
    exp_ack.push_back(1'b1);
    exp_byte.push_back(d[7:0]);
    exp_byte.push_back(d[15:8]);
    exp_done.push_back(1'b1);
  endtask

  task automatic send_reg(input logic [7:0] d, output int lat);
    push_reg(d);
    REG_DATA  = d;
    REG_VALID = 1'b1;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (!REG_ACK && lat < 400);
    if (!REG_ACK) check("reg_ack_timeout", {31'd0, REG_ACK}, 32'd1);
    REG_VALID = 1'b0;
    REG_DATA  = 8'($urandom);
  endtask

  task automatic send_alu(input logic [15:0] d, output int lat);
    push_alu(d);
    ALU_DATA  = d;
    ALU_VALID = 1'b1;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (!ALU_ACK && lat < 400);
    if (!ALU_ACK) check("alu_ack_timeout", {31'd0, ALU_ACK}, 32'd1);
    ALU_VALID = 1'b0;
    ALU_DATA  = 16'($urandom);
  endtask

  task automatic wait_quiet();
    int n = 0;
    do begin @(posedge CLK); #1; n++; end
    while ((SCHED_BUSY || TX_BUSY || exp_byte.size() != 0 || exp_done.size() != 0) && n < 2000);
    if (n >= 2000) check("quiet_timeout", n, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p_data"}, {24'd0, TX_P_DATA}, 32'h00);
    check({tag, "_data_valid"}, {31'd0, TX_DATA_VALID}, 32'd0);
    check({tag, "_reg_ack"}, {31'd0, REG_ACK}, 32'd0);
    check({tag, "_alu_ack"}, {31'd0, ALU_ACK}, 32'd0);
    check({tag, "_sched_busy"}, {31'd0, SCHED_BUSY}, 32'd0);
    check({tag, "_msg_done"}, {31'd0, MSG_DONE}, 32'd0);
    check({tag, "_msg_src"}, {31'd0, MSG_SRC}, 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int base;

    RST = 1'b1;
    g_reg_valid = 1'b0; g_reg_data = 8'h00;
    g_alu_valid = 1'b0; g_alu_data = 16'h0000;
    g_tx_busy   = 1'b0;

    // Both sources held high from reset: strict alternation starting with REG.
    REG_VALID = 1'b1; REG_DATA = 8'h11;
    ALU_VALID = 1'b1; ALU_DATA = 16'hBEEF;
    push_reg(8'h11); push_alu(16'hBEEF); push_reg(8'h11); push_alu(16'hBEEF);
    repeat (3) begin @(posedge CLK); #1; end
    check_reset_outputs("reset");
    spacing_on = 1'b1;
    RST = 1'b0;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (ack_cnt < 4 && n < 2000);
    check("alt_ack_count", ack_cnt, 4);
    REG_VALID = 1'b0;
    ALU_VALID = 1'b0;
    wait_quiet();
    spacing_on = 1'b0;
    check("alt_done_count", done_cnt, 4);

    // Single REG message: ACK and start strobe one cycle after the request.
    base = done_cnt;
    send_reg(8'hA5, lat);
    check("reg_ack_latency", lat, 1);
    check("reg_issue_with_ack", {31'd0, TX_DATA_VALID}, 32'd1);
    wait_quiet();
    check("reg_done_count", done_cnt - base, 1);

    // Single ALU message: two frames, exactly one MSG_DONE.
    base = done_cnt;
    send_alu(16'h1234, lat);
    check("alu_ack_latency", lat, 1);
    wait_quiet();
    check("alu_done_count", done_cnt - base, 1);

    // REG request arriving mid-ALU-frame waits for the ALU MSG_DONE.
    base = done_cnt;
    send_alu(16'h2468, lat);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!TX_BUSY && n < 50);
    check("mid_frame_busy", {31'd0, TX_BUSY}, 32'd1);
    send_reg(8'h3C, lat);
    check("mid_frame_ack_after_done", done_cnt - base, 1);
    wait_quiet();
    check("mid_frame_done_count", done_cnt - base, 2);

    // Reset during the second ALU byte; REG then ALU are served afterwards.
    base = issue_cnt;
    send_alu(16'hCAFE, lat);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (issue_cnt < base + 2 && n < 200);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!TX_BUSY && n < 50);
    check("rst_second_byte_busy", {31'd0, TX_BUSY}, 32'd1);
    exp_done.delete();
    base = done_cnt;
    RST = 1'b1;
    REG_VALID = 1'b1; REG_DATA = 8'h77;
    ALU_VALID = 1'b1; ALU_DATA = 16'h0F0F;
    push_reg(8'h77); push_alu(16'h0F0F);
    @(posedge CLK); #1;
    check_reset_outputs("midrst");
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(posedge CLK); #1; n++; end while (!REG_ACK && !ALU_ACK && n < 400);
      if (REG_ACK) REG_VALID = 1'b0;
      if (ALU_ACK) ALU_VALID = 1'b0;
    end
    check("midrst_valids_served", {30'd0, REG_VALID, ALU_VALID}, 32'd0);
    wait_quiet();
    check("midrst_done_count", done_cnt - base, 2);

    // GAP_CYCLES=3 instance: Busy fall of 0x5A to start strobe of 0xA5 is 4 cycles.
    g_alu_data  = 16'hA55A;
    g_alu_valid = 1'b1;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!g_alu_ack && n < 20);
    check("gap_ack_latency", n, 1);
    check("gap_first_strobe", {31'd0, g_tx_data_valid}, 32'd1);
    check("gap_first_byte", {24'd0, g_tx_p_data}, 32'h5A);
    g_alu_valid = 1'b0;
    g_alu_data  = 16'h0000;
    repeat (2) begin @(posedge CLK); #1; end
    g_tx_busy = 1'b1;
    repeat (4) begin @(posedge CLK); #1; end
    g_tx_busy = 1'b0;
    n = 0;
    do begin
      @(posedge CLK); #1; n++;
      if (n == 1) begin
        check("gap_no_early_done", {31'd0, g_msg_done}, 32'd0);
        check("gap_p_data_held", {24'd0, g_tx_p_data}, 32'h5A);
        check("gap_sched_busy", {31'd0, g_sched_busy}, 32'd1);
      end
    end while (!g_tx_data_valid && n < 20);
    check("gap_busy_fall_to_strobe", n, 4);
    check("gap_second_byte", {24'd0, g_tx_p_data}, 32'hA5);
    repeat (2) begin @(posedge CLK); #1; end
    g_tx_busy = 1'b1;
    repeat (4) begin @(posedge CLK); #1; end
    g_tx_busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        check("gap_msg_done", {31'd0, g_msg_done}, 32'd1);
        check("gap_msg_src", {31'd0, g_msg_src}, 32'd1);
      end
      if (k == 3) check("gap_tail_busy", {31'd0, g_sched_busy}, 32'd1);
      if (k == 4) check("gap_back_idle", {31'd0, g_sched_busy}, 32'd0);
    end

    check("left_exp_ack", exp_ack.size(), 0);
    check("left_exp_byte", exp_byte.size(), 0);
    check("left_exp_done", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
